// File: rtl/noc_port_control_param.sv
// noc_port_control_param: two-stage port/VC arbitration with per-channel route FIFOs.
module noc_port_arb #(
    parameter int N        = 2,
    parameter int ARB_MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] free,
    output logic [N-1:0] gnt
);
    localparam int PW = $clog2(N);
    logic          locked_q, locked_d;
    logic [N-1:0]  hold_q, hold_d, pick;
    logic [PW-1:0] ptr_q, ptr_d, nxt;
    logic          found, rel;
    int            idx;
    always_comb begin
        pick  = '0;
        found = 1'b0;
        nxt   = ptr_q;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (ARB_MODE == 1) ? i : (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
                nxt       = PW'((idx + 1) % N);
            end
        end
        gnt      = locked_q ? hold_q : pick;
        rel      = |(gnt & free);
        // A grant released in the same idle cycle never locks: single-cycle grant
        locked_d = locked_q ? !rel : found && !rel;
        hold_d   = locked_q ? hold_q : pick;
        ptr_d    = (!locked_q && ARB_MODE == 0) ? nxt : ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
            hold_q   <= '0;
            ptr_q    <= '0;
        end else begin
            locked_q <= locked_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
        end
    end
endmodule

module noc_port_control_param #(
    parameter int PORTS       = 5,
    parameter int CHANNELS    = 2,
    parameter int ROUTE_DEPTH = 2,
    parameter int ARB_MODE    = 0
) (
    input  logic                                               noc_clk,
    input  logic                                               noc_rst_n,
    input  logic [PORTS-1:0][CHANNELS-1:0]                     sop_i,
    input  logic [PORTS-1:0][CHANNELS-1:0]                     eop_i,
    input  logic [PORTS-1:0][CHANNELS-1:0]                     vc_req_i,
    input  logic [PORTS-1:0][CHANNELS-1:0]                     vc_free_i,
    input  logic [CHANNELS-1:0]                                vc_ready_i,
    output logic [PORTS-1:0][CHANNELS-1:0]                     grant_o,
    output logic [CHANNELS-1:0][PORTS-1:0]                     route_o,
    output logic [CHANNELS-1:0]                                route_valid_o,
    input  logic [CHANNELS-1:0]                                route_pop_i,
    output logic [CHANNELS-1:0][$clog2(ROUTE_DEPTH+1)-1:0]     route_count_o,
    output logic [CHANNELS-1:0]                                overflow_o
);
    localparam int CW = $clog2(ROUTE_DEPTH + 1);
    localparam int PW = $clog2(ROUTE_DEPTH);
    logic [CHANNELS-1:0][PORTS-1:0] pg;
    logic [PORTS-1:0][CHANNELS-1:0] vg, qf;
    logic [CHANNELS-1:0]            full;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_port
        logic [PORTS-1:0] req, rel;
        for (genvar p = 0; p < PORTS; p++) begin : g_col
            assign req[p] = sop_i[p][c];
            assign rel[p] = eop_i[p][c];
        end
        noc_port_arb #(.N(PORTS), .ARB_MODE(ARB_MODE)) u_arb (
            .clk(noc_clk), .rst_n(noc_rst_n), .req(req), .free(rel), .gnt(pg[c])
        );
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_vc
        logic [CHANNELS-1:0] req;
        for (genvar c = 0; c < CHANNELS; c++) begin : g_bit
            assign req[c]        = vc_req_i[p][c] & pg[c][p] & vc_ready_i[c];
            assign qf[p][c]      = vc_free_i[p][c] & pg[c][p];
            assign grant_o[p][c] = vg[p][c] & ~full[c] & noc_rst_n;
        end
        if (CHANNELS >= 2) begin : g_arb
            noc_port_arb #(.N(CHANNELS), .ARB_MODE(ARB_MODE)) u_arb (
                .clk(noc_clk), .rst_n(noc_rst_n), .req(req), .free(qf[p]), .gnt(vg[p])
            );
        end else begin : g_comb
            assign vg[p] = req;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
        logic [ROUTE_DEPTH-1:0][PORTS-1:0] mem_q, mem_d;
        logic [PW-1:0]                     wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0]                     cnt_q, cnt_d;
        logic                              ovf_q, ovf_d, push, pop, acc;
        logic [PORTS-1:0]                  wdata;
        always_comb begin
            for (int i = 0; i < PORTS; i++) wdata[i] = qf[i][c];
            push  = |wdata;
            pop   = route_pop_i[c] && cnt_q != '0;
            // A pop in the same cycle frees the slot, so a push while full still lands
            acc   = push && (!full[c] || pop);
            mem_d = mem_q;
            if (acc) mem_d[wr_q] = wdata;
            wr_d  = acc ? (wr_q == PW'(ROUTE_DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
            rd_d  = pop ? (rd_q == PW'(ROUTE_DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
            cnt_d = cnt_q + CW'(acc) - CW'(pop);
            ovf_d = ovf_q | (push & full[c] & ~pop);
        end
        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
                mem_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                mem_q <= mem_d;
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end
        assign full[c]          = cnt_q == CW'(ROUTE_DEPTH);
        assign route_o[c]       = (cnt_q != '0) ? mem_q[rd_q] : '0;
        assign route_valid_o[c] = cnt_q != '0;
        assign route_count_o[c] = cnt_q;
        assign overflow_o[c]    = ovf_q;
    end
endmodule

// File: tb/tb_noc_port_control_param.sv
// tb_noc_port_control_param: two configurations checked against a cycle-level reference model.
module tb_noc_port_control_param;
    localparam int P = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [P-1:0][1:0] sop, eop, vreq, vfree;
    logic [1:0]        rdy, pop;
    logic [P-1:0][1:0] gnt_a;
    logic [1:0][P-1:0] route_a;
    logic [1:0]        rv_a, ovf_a;
    logic [1:0][1:0]   cnt_a;
    logic [P-1:0][0:0] sop_b, eop_b, vreq_b, vfree_b, gnt_b;
    logic [0:0][P-1:0] route_b;
    logic [0:0]        rv_b, ovf_b;
    logic [0:0][1:0]   cnt_b;
    bit                pl[2][2], ov[2][2], vl[P];
    int                ph[2][2], pp[2][2], vh[P], vp[P];
    logic [P-1:0]      rq[2][2][$];
    int                n_chk = 0, n_fail = 0;
    logic              last;

    always #5 clk = ~clk;

    always_comb
        for (int p = 0; p < P; p++) begin
            sop_b[p]   = sop[p][0];
            eop_b[p]   = eop[p][0];
            vreq_b[p]  = vreq[p][0];
            vfree_b[p] = vfree[p][0];
        end

    noc_port_control_param #(.PORTS(P), .CHANNELS(2), .ROUTE_DEPTH(2), .ARB_MODE(0)) u_a (
        .noc_clk(clk), .noc_rst_n(rst_n), .sop_i(sop), .eop_i(eop), .vc_req_i(vreq),
        .vc_free_i(vfree), .vc_ready_i(rdy), .grant_o(gnt_a), .route_o(route_a),
        .route_valid_o(rv_a), .route_pop_i(pop), .route_count_o(cnt_a), .overflow_o(ovf_a)
    );

    noc_port_control_param #(.PORTS(P), .CHANNELS(1), .ROUTE_DEPTH(3), .ARB_MODE(1)) u_b (
        .noc_clk(clk), .noc_rst_n(rst_n), .sop_i(sop_b), .eop_i(eop_b), .vc_req_i(vreq_b),
        .vc_free_i(vfree_b), .vc_ready_i(rdy[0:0]), .grant_o(gnt_b), .route_o(route_b),
        .route_valid_o(rv_b), .route_pop_i(pop[0:0]), .route_count_o(cnt_b), .overflow_o(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [P-1:0] req, input int n, input int md, input int ptr);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = md ? i : (ptr + i) % n;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // Instance k: k=0 is round-robin/2 channels/depth 2, k=1 is fixed-priority/1 channel/depth 3
    task automatic model();
        for (int k = 0; k < 2; k++) begin
            int nc, dp, pgi[2], vgi[P];
            logic [P-1:0][1:0] eg, og;
            logic [P-1:0] col, qd, hd;
            bit rel, dq, ful;
            nc = 2 - k;
            dp = 2 + k;
            if (!rst_n) begin
                for (int c = 0; c < 2; c++) begin
                    pl[k][c] = 0; pp[k][c] = 0; ov[k][c] = 0; rq[k][c].delete();
                end
                for (int p = 0; p < P; p++) begin vl[p] = 0; vp[p] = 0; end
            end
            eg = '0;
            pgi = '{-1, -1};
            for (int p = 0; p < P; p++) vgi[p] = -1;
            for (int c = 0; c < nc; c++) begin
                for (int p = 0; p < P; p++) col[p] = sop[p][c];
                pgi[c] = pl[k][c] ? ph[k][c] : pick(col, P, k, pp[k][c]);
            end
            for (int p = 0; p < P; p++) begin
                if (k == 0) begin
                    col = '0;
                    for (int c = 0; c < 2; c++) col[c] = vreq[p][c] && pgi[c] == p && rdy[c];
                    vgi[p] = vl[p] ? vh[p] : pick(col, 2, 0, vp[p]);
                    for (int c = 0; c < 2; c++) eg[p][c] = rst_n && vgi[p] == c && rq[0][c].size() < dp;
                end else
                    eg[p][0] = rst_n && vreq[p][0] && pgi[0] == p && rdy[0] && rq[1][0].size() < dp;
            end
            for (int p = 0; p < P; p++)
                for (int c = 0; c < 2; c++) og[p][c] = (k == 0) ? gnt_a[p][c] : (c == 0 && gnt_b[p][0]);
            chk($sformatf("grant_k%0d", k), 32'(og), 32'(eg));
            for (int c = 0; c < nc; c++) begin
                hd = rq[k][c].size() > 0 ? rq[k][c][0] : '0;
                chk($sformatf("route_k%0d_c%0d", k, c), 32'(k == 0 ? route_a[c] : route_b[0]), 32'(hd));
                chk($sformatf("valid_k%0d_c%0d", k, c), 32'(k == 0 ? rv_a[c] : rv_b[0]), 32'(rq[k][c].size() > 0));
                chk($sformatf("count_k%0d_c%0d", k, c), 32'(k == 0 ? cnt_a[c] : cnt_b[0]), 32'(rq[k][c].size()));
                chk($sformatf("ovf_k%0d_c%0d", k, c), 32'(k == 0 ? ovf_a[c] : ovf_b[0]), 32'(ov[k][c]));
            end
            if (rst_n) begin
                for (int c = 0; c < nc; c++) begin
                    if (pgi[c] >= 0) begin
                        rel = eop[pgi[c]][c];
                        if (!pl[k][c] && k == 0) pp[k][c] = (pgi[c] + 1) % P;
                        pl[k][c] = !rel;
                        ph[k][c] = pgi[c];
                    end
                    for (int p = 0; p < P; p++) qd[p] = vfree[p][c] && pgi[c] == p;
                    ful = rq[k][c].size() == dp;
                    dq  = pop[c] && rq[k][c].size() > 0;
                    if (dq) void'(rq[k][c].pop_front());
                    if (qd != '0) begin
                        if (!ful || dq) rq[k][c].push_back(qd);
                        else ov[k][c] = 1;
                    end
                end
                if (k == 0)
                    for (int p = 0; p < P; p++)
                        if (vgi[p] >= 0) begin
                            rel = vfree[p][vgi[p]] && pgi[vgi[p]] == p;
                            if (!vl[p]) vp[p] = (vgi[p] + 1) % 2;
                            vl[p] = !rel;
                            vh[p] = vgi[p];
                        end
            end
        end
    endtask

    task automatic settle();
        #1 model();
    endtask

    task automatic cyc();
        settle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        sop = '0; eop = '0; vreq = '0; vfree = '0; rdy = '0; pop = '0;
        settle(); chk("rst_grant", 32'(gnt_a), 0); chk("rst_valid", 32'(rv_a), 0); @(negedge clk);
        rst_n = 1'b1; rdy = 2'b11;
        sop[1][0] = 1; sop[3][0] = 1; vreq[1][0] = 1; vreq[3][0] = 1;
        settle(); chk("first_p1", gnt_a[1][0], 1); chk("first_p3_waits", gnt_a[3][0], 0); @(negedge clk);
        sop[1][0] = 0;
        cyc();
        eop[1][0] = 1; vfree[1][0] = 1;
        settle(); chk("free_cycle_held", gnt_a[1][0], 1); @(negedge clk);
        eop[1][0] = 0; vfree[1][0] = 0;
        settle();
        chk("route_head", route_a[0], 5'b00010); chk("route_valid", rv_a[0], 1); chk("next_p3", gnt_a[3][0], 1);
        @(negedge clk);
        sop[3][0] = 0; eop[3][0] = 1; vfree[3][0] = 1;
        cyc();
        eop[3][0] = 0; vfree[3][0] = 0; vreq[1][0] = 0; vreq[3][0] = 0;
        settle(); chk("full_count", cnt_a[0], 2); @(negedge clk);
        sop[2][0] = 1; vreq[2][0] = 1;
        settle(); chk("full_blocks_grant", gnt_a[2][0], 0); @(negedge clk);
        sop[2][0] = 0; eop[2][0] = 1; vfree[2][0] = 1;
        cyc();
        eop[2][0] = 0; vfree[2][0] = 0; vreq[2][0] = 0;
        settle(); chk("overflow_set", ovf_a[0], 1); chk("overflow_count", cnt_a[0], 2); @(negedge clk);
        pop[0] = 1;
        settle(); chk("pop_first", route_a[0], 5'b00010); @(negedge clk);
        settle(); chk("pop_second", route_a[0], 5'b01000); @(negedge clk);
        cyc(); cyc();
        sop[2][0] = 1; sop[4][0] = 1; vreq[2][0] = 1; vreq[4][0] = 1;
        eop[2][0] = 1; eop[4][0] = 1; vfree[2][0] = 1; vfree[4][0] = 1;
        last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("fixed_prio_p2", gnt_b[2][0], 1);
            chk("rr_one_winner", gnt_a[2][0] ^ gnt_a[4][0], 1);
            if (i > 0) chk("rr_alternate", gnt_a[2][0], !last);
            last = gnt_a[2][0];
            @(negedge clk);
        end
        sop = '0; eop = '0; vreq = '0; vfree = '0;
        cyc(); cyc(); cyc();
        pop = '0; rdy = 2'b00; sop[0][0] = 1; vreq[0][0] = 1;
        settle(); chk("c1_not_ready", gnt_b[0][0], 0); @(negedge clk);
        rdy = 2'b01;
        settle(); chk("c1_ready", gnt_b[0][0], 1); @(negedge clk);
        eop[0][0] = 1; vfree[0][0] = 1;
        cyc();
        eop[0][0] = 0; vfree[0][0] = 0;
        settle(); chk("relock_queued", rv_a[0], 1); chk("relock_grant", gnt_a[0][0], 1); @(negedge clk);
        rst_n = 1'b0;
        settle();
        chk("rst_mid_grant", 32'(gnt_a), 0); chk("rst_mid_valid", rv_a[0], 0);
        chk("rst_mid_count", cnt_a[0], 0); chk("rst_mid_route", route_a[0], 0);
        @(negedge clk);
        rst_n = 1'b1; sop = '0;
        settle(); chk("post_rst_nogrant", 32'(gnt_a), 0); @(negedge clk);
        sop[0][0] = 1;
        settle(); chk("post_rst_regrant", gnt_a[0][0], 1); @(negedge clk);
        for (int i = 0; i < 800; i++) begin
            sop   = 10'($urandom);
            vreq  = 10'($urandom);
            eop   = 10'($urandom & $urandom & $urandom);
            vfree = 10'($urandom & $urandom);
            rdy   = 2'($urandom | $urandom);
            pop   = 2'($urandom & $urandom);
            rst_n = $urandom_range(0, 63) != 0;
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
